dmem_bus_ctrl: RTL and testbench

DMEM_BUS_CTRL -- requirements
Module: dmem_bus_ctrl

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_bus_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_dmem_bus_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory bus controller
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [6:0] OPC_LOAD        = 7'b0000011;
  localparam logic [6:0] OPC_STORE       = 7'b0100011;
  localparam int         TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/dmem_bus_ctrl.sv
// rtl/dmem_bus_ctrl.sv - load/store bus sequencer with pipeline stall, response capture and timeout fault
module dmem_bus_ctrl
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_req,
  input  logic        st_req,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        fault
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [29:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wmask_q;
  logic          is_load_q;
  logic          flt_q;
  logic          ok_q;
  logic [31:0]   rdata_q;

  logic accept;
  logic illegal;
  logic timeout;

  assign accept  = ld_req ^ st_req;
  assign illegal = ld_req & st_req;
  // >= rather than == so a grant on the last REQ cycle still times out in RESP
  assign timeout = (cnt >= CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (illegal) begin
          state_nxt = ST_DONE;
        end else if (st_req && (wmask == 4'b0000)) begin
          state_nxt = ST_DONE;
        end else if (accept) begin
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          if (!is_load_q || mem_rvalid) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_RESP;
          end
        end else if (timeout) begin
          state_nxt = ST_DONE;
        end
      end
      ST_RESP: begin
        if (mem_rvalid || timeout) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    stall       = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    fault       = 1'b0;
    rdata_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        stall = ld_req | st_req;
      end
      ST_REQ: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        mem_we  = ~is_load_q;
      end
      ST_RESP: begin
        stall = 1'b1;
      end
      ST_DONE: begin
        fault       = flt_q;
        rdata_valid = ok_q;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

  // Request registers, response capture and completion flags consumed in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      is_load_q <= 1'b0;
      flt_q     <= 1'b0;
      ok_q      <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt   <= '0;
          ok_q  <= 1'b0;
          flt_q <= illegal;
          if (accept) begin
            addr_q    <= addr[31:2];
            wdata_q   <= wdata;
            wmask_q   <= st_req ? wmask : 4'b0000;
            is_load_q <= ld_req;
          end
        end
        ST_REQ: begin
          cnt <= cnt + 1'b1;
          if (mem_gnt && is_load_q && mem_rvalid) begin
            rdata_q <= mem_rdata;
            ok_q    <= 1'b1;
          end else if (!mem_gnt && timeout) begin
            flt_q <= 1'b1;
          end
        end
        ST_RESP: begin
          cnt <= cnt + 1'b1;
          if (mem_rvalid) begin
            rdata_q <= mem_rdata;
            ok_q    <= 1'b1;
          end else if (timeout) begin
            flt_q <= 1'b1;
          end
        end
        ST_DONE: begin
          flt_q <= 1'b0;
          ok_q  <= 1'b0;
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  assign mem_addr  = {addr_q, 2'b00};
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// tb/tb_dmem_bus_ctrl.sv - directed self-checking bench for dmem_bus_ctrl
module tb_dmem_bus_ctrl;

  logic        clk;
  logic        rst;
  logic        ld_req;
  logic        st_req;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        fault;

  int n_cmp = 0;
  int n_bad = 0;

  int          r_stalls;
  int          r_reqs;
  logic        r_done;
  logic        r_fault;
  logic        r_rdv;
  logic        r_req_at_done;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wmask;
  logic        r_we;

  dmem_bus_ctrl #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .ld_req(ld_req), .st_req(st_req),
    .addr(addr), .wdata(wdata), .wmask(wmask),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Drives one request from IDLE; bus answers at the given cycle indices (-1 = never)
  task automatic run_txn(input logic ld, input logic st, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] wm,
                         input int gnt_at, input int rv_at, input logic [31:0] rv_data);
    r_stalls = 0; r_reqs = 0; r_done = 1'b0; r_fault = 1'b0; r_rdv = 1'b0;
    r_req_at_done = 1'b0; r_addr = '0; r_wdata = '0; r_wmask = '0; r_we = 1'b0;
    addr = a; wdata = wd; wmask = wm;
    for (int i = 0; i < 40; i++) begin
      ld_req     = (i == 0) ? ld : 1'b0;
      st_req     = (i == 0) ? st : 1'b0;
      mem_gnt    = (i == gnt_at);
      mem_rvalid = (i == rv_at);
      mem_rdata  = (i == rv_at) ? rv_data : 32'h5A5A_5A5A;
      #1;
      if (!stall) begin
        r_done = 1'b1;
        r_fault = fault;
        r_rdv = rdata_valid;
        r_req_at_done = mem_req;
        break;
      end
      r_stalls++;
      if (mem_req) begin
        if (r_reqs == 0) begin
          r_addr = mem_addr; r_wdata = mem_wdata; r_wmask = mem_wmask; r_we = mem_we;
        end
        r_reqs++;
      end
      @(posedge clk);
      #2;
    end
    check_val("txn_completes", {31'b0, r_done}, 32'd1);
    ld_req = 1'b0; st_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ld_req = 0; st_req = 0; addr = '0; wdata = '0; wmask = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    repeat (3) tick;
    rst = 1'b0;
    #1;
    check_val("rst_stall", {31'b0, stall}, 0);
    check_val("rst_mem_req", {31'b0, mem_req}, 0);
    check_val("rst_rdata", rdata, 32'h0);
    check_val("rst_fault", {31'b0, fault}, 0);
    check_val("rst_mem_addr", mem_addr, 32'h0);
    tick;

    // store, grant on first REQ cycle
    run_txn(0, 1, 32'h0000_1006, 32'hBEEF_0000, 4'b1100, 1, -1, 0);
    check_val("st_stalls", r_stalls, 2);
    check_val("st_reqs", r_reqs, 1);
    check_val("st_addr", r_addr, 32'h0000_1004);
    check_val("st_we", {31'b0, r_we}, 1);
    check_val("st_wmask", {28'b0, r_wmask}, 4'b1100);
    check_val("st_wdata", r_wdata, 32'hBEEF_0000);
    check_val("st_fault", {31'b0, r_fault}, 0);
    check_val("st_rdv", {31'b0, r_rdv}, 0);
    tick;
    check_val("st_idle_stall", {31'b0, stall}, 0);

    // load, grant on 4th REQ cycle, response two cycles later
    run_txn(1, 0, 32'h0000_0020, 32'hFFFF_FFFF, 4'b1111, 4, 6, 32'h1234_5678);
    check_val("ld_stalls", r_stalls, 7);
    check_val("ld_reqs", r_reqs, 4);
    check_val("ld_addr", r_addr, 32'h0000_0020);
    check_val("ld_we", {31'b0, r_we}, 0);
    check_val("ld_wmask", {28'b0, r_wmask}, 0);
    check_val("ld_rdv", {31'b0, r_rdv}, 1);
    check_val("ld_rdata", rdata, 32'h1234_5678);
    tick;
    check_val("ld_rdv_pulse", {31'b0, rdata_valid}, 0);
    check_val("ld_rdata_hold", rdata, 32'h1234_5678);

    // load, grant and response in the same cycle
    run_txn(1, 0, 32'h0000_0047, 0, 0, 1, 1, 32'hCAFE_F00D);
    check_val("ldq_stalls", r_stalls, 2);
    check_val("ldq_addr", r_addr, 32'h0000_0044);
    check_val("ldq_rdv", {31'b0, r_rdv}, 1);
    check_val("ldq_rdata", rdata, 32'hCAFE_F00D);
    tick;

    // load, never granted: 15 REQ cycles then fault
    run_txn(1, 0, 32'h0000_0100, 0, 0, -1, -1, 0);
    check_val("to_stalls", r_stalls, 16);
    check_val("to_reqs", r_reqs, 15);
    check_val("to_fault", {31'b0, r_fault}, 1);
    check_val("to_rdv", {31'b0, r_rdv}, 0);
    check_val("to_req_drop", {31'b0, r_req_at_done}, 0);
    check_val("to_rdata", rdata, 32'hCAFE_F00D);
    tick;
    check_val("to_fault_pulse", {31'b0, fault}, 0);

    // load granted, response never arrives: timeout in RESP
    run_txn(1, 0, 32'h0000_0200, 0, 0, 1, -1, 0);
    check_val("tor_stalls", r_stalls, 16);
    check_val("tor_fault", {31'b0, r_fault}, 1);
    check_val("tor_rdata", rdata, 32'hCAFE_F00D);
    tick;

    // simultaneous load and store
    run_txn(1, 1, 32'h0000_0300, 0, 4'b1111, 1, 1, 32'h7777_7777);
    check_val("ill_stalls", r_stalls, 1);
    check_val("ill_reqs", r_reqs, 0);
    check_val("ill_fault", {31'b0, r_fault}, 1);
    check_val("ill_rdata", rdata, 32'hCAFE_F00D);
    tick;

    // store with empty mask
    run_txn(0, 1, 32'h0000_0400, 32'h1111_2222, 4'b0000, 1, -1, 0);
    check_val("nomask_stalls", r_stalls, 1);
    check_val("nomask_reqs", r_reqs, 0);
    check_val("nomask_fault", {31'b0, r_fault}, 0);
    tick;

    // stray response while idle is ignored
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    tick;
    check_val("idle_rv_rdata", rdata, 32'hCAFE_F00D);
    check_val("idle_rv_rdv", {31'b0, rdata_valid}, 0);
    mem_rvalid = 1'b0; mem_rdata = '0;
    tick;

    // store granted after 3 REQ cycles
    run_txn(0, 1, 32'h0000_0503, 32'h0000_00AB, 4'b1000, 3, -1, 0);
    check_val("stl_stalls", r_stalls, 4);
    check_val("stl_reqs", r_reqs, 3);
    check_val("stl_addr", r_addr, 32'h0000_0500);
    tick;

    // reset while waiting in RESP, then a late response
    addr = 32'h0000_0600; ld_req = 1'b1;
    tick;
    ld_req = 1'b0; mem_gnt = 1'b1;
    tick;
    mem_gnt = 1'b0;
    tick;
    check_val("rr_in_resp_stall", {31'b0, stall}, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    check_val("rr_stall", {31'b0, stall}, 0);
    check_val("rr_mem_req", {31'b0, mem_req}, 0);
    check_val("rr_mem_addr", mem_addr, 32'h0);
    check_val("rr_mem_wmask", {28'b0, mem_wmask}, 0);
    check_val("rr_rdata", rdata, 32'h0);
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick;
    mem_rvalid = 1'b0; mem_rdata = '0;
    check_val("rr_late_rdata", rdata, 32'h0);
    check_val("rr_late_rdv", {31'b0, rdata_valid}, 0);
    check_val("rr_late_stall", {31'b0, stall}, 0);
    tick;

    // controller is back in IDLE and serves a fresh store
    run_txn(0, 1, 32'h0000_0008, 32'h0102_0304, 4'b1111, 1, -1, 0);
    check_val("post_stalls", r_stalls, 2);
    check_val("post_addr", r_addr, 32'h0000_0008);
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
